// File: rtl/quad_pkg.sv
// Shared types and quadrature sequence tables for the quadrature transmitter.
package quad_pkg;

  typedef enum logic {
    DIR_CW  = 1'b0,
    DIR_CCW = 1'b1
  } dir_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // {a,b} indexed by quarter index; index 0 is the idle/cycle-boundary level 00.
  localparam logic [1:0] CW_SEQ  [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  localparam logic [1:0] CCW_SEQ [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  // Output level {a,b} for a given direction and quarter index.
  function automatic logic [1:0] seq_value(input dir_t dir, input logic [1:0] idx);
    logic [1:0] val;
    if (dir == DIR_CCW) begin
      val = CCW_SEQ[idx];
    end else begin
      val = CW_SEQ[idx];
    end
    return val;
  endfunction

endpackage

// File: rtl/quad_phase_timer.sv
// Dwell timer: counts 0..QTR_CYCLES-1 while enabled and pulses tick at the wrap.
module quad_phase_timer #(
  parameter int QTR_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = $clog2(QTR_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(QTR_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;

  // Dwell counter; clear wins over counting so a new command starts a full dwell.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (enable) begin
      if (cnt_r == LAST) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + ONE;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tick = enable && !clear && (cnt_r == LAST);

endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature transmitter: turns step commands into A/B encoder waveforms and
// keeps a saturating position mirror. Optional bounce bursts on every edge are
// enabled with the QUAD_BOUNCE_EN macro.
module quad_encoder_gen
  import quad_pkg::*;
#(
  parameter int QTR_CYCLES    = 1000,
  parameter int POS_MAX       = 20000,
  parameter int BOUNCE_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_dir,
  input  logic [15:0] cmd_steps,
  input  logic        abort,
  output logic        a,
  output logic        b,
  output logic        busy,
  output logic        done,
  output logic [15:0] steps_done,
  output logic [15:0] position
);

  localparam logic [15:0] POS_LIM = 16'(POS_MAX);

  if ((BOUNCE_CYCLES % 2) != 0 || QTR_CYCLES < 4) begin : g_param_check
    $error("quad_encoder_gen: QTR_CYCLES must be >= 4 and BOUNCE_CYCLES even");
  end

  state_t      state_r, state_nxt_s;
  dir_t        dir_r, dir_nxt_s;
  logic [15:0] steps_r, steps_nxt_s;
  logic [15:0] steps_done_r, steps_done_nxt_s;
  logic [15:0] position_r, position_nxt_s;
  logic [1:0]  qidx_r, qidx_nxt_s;
  logic [1:0]  ab_r, ab_nxt_s;
  logic        abort_r, abort_nxt_s;
  logic        done_r, done_nxt_s;
  logic        accept_s;
  logic        tick_s;

  quad_phase_timer #(
    .QTR_CYCLES(QTR_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (accept_s),
    .enable  (state_r == RUN),
    .tick    (tick_s)
  );

  // State and datapath registers; reset returns the lines straight to 00.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      dir_r        <= DIR_CW;
      steps_r      <= 16'd0;
      steps_done_r <= 16'd0;
      position_r   <= 16'd0;
      qidx_r       <= 2'd0;
      ab_r         <= 2'b00;
      abort_r      <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      dir_r        <= dir_nxt_s;
      steps_r      <= steps_nxt_s;
      steps_done_r <= steps_done_nxt_s;
      position_r   <= position_nxt_s;
      qidx_r       <= qidx_nxt_s;
      ab_r         <= ab_nxt_s;
      abort_r      <= abort_nxt_s;
      done_r       <= done_nxt_s;
    end
  end

  // Next-state logic: command acceptance, quarter stepping and cycle completion.
  always_comb begin
    state_nxt_s      = state_r;
    dir_nxt_s        = dir_r;
    steps_nxt_s      = steps_r;
    steps_done_nxt_s = steps_done_r;
    position_nxt_s   = position_r;
    qidx_nxt_s       = qidx_r;
    ab_nxt_s         = ab_r;
    abort_nxt_s      = abort_r;
    done_nxt_s       = 1'b0;
    accept_s         = 1'b0;
    case (state_r)
      IDLE: begin
        if (cmd_valid) begin
          accept_s         = 1'b1;
          dir_nxt_s        = dir_t'(cmd_dir);
          steps_nxt_s      = cmd_steps;
          steps_done_nxt_s = 16'd0;
          qidx_nxt_s       = 2'd0;
          abort_nxt_s      = 1'b0;
          if (cmd_steps != 16'd0) begin
            state_nxt_s = RUN;
          end else begin
            // Zero-length command: no edges, just acknowledge it.
            done_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        abort_nxt_s = abort_r | abort;
        if (tick_s) begin
          qidx_nxt_s = qidx_r + 2'd1;
          ab_nxt_s   = seq_value(dir_r, qidx_r + 2'd1);
          if (qidx_r == 2'd3) begin
            // Back at 00: one full quadrature cycle has been emitted.
            steps_done_nxt_s = steps_done_r + 16'd1;
            if (dir_r == DIR_CW) begin
              if (position_r >= POS_LIM) begin
                position_nxt_s = POS_LIM;
              end else begin
                position_nxt_s = position_r + 16'd1;
              end
            end else begin
              if (position_r == 16'd0) begin
                position_nxt_s = 16'd0;
              end else begin
                position_nxt_s = position_r - 16'd1;
              end
            end
            if ((steps_done_nxt_s == steps_r) || abort_nxt_s) begin
              state_nxt_s = IDLE;
              done_nxt_s  = 1'b1;
            end else begin
              state_nxt_s = RUN;
            end
          end else begin
            state_nxt_s = RUN;
          end
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  assign cmd_ready  = (state_r == IDLE);
  assign busy       = (state_r == RUN);
  assign done       = done_r;
  assign steps_done = steps_done_r;
  assign position   = position_r;

`ifdef QUAD_BOUNCE_EN
  if ((BOUNCE_CYCLES < 2) || (BOUNCE_CYCLES >= QTR_CYCLES / 2)) begin : g_bounce_check
    $error("quad_encoder_gen: BOUNCE_CYCLES must be >= 2 and < QTR_CYCLES/2");
  end

  localparam int BNC_W = $clog2(BOUNCE_CYCLES + 1);
  localparam logic [BNC_W-1:0] BNC_LAST = BNC_W'(BOUNCE_CYCLES);
  localparam logic [BNC_W-1:0] BNC_ONE  = BNC_W'(1);

  logic [1:0]       out_r;
  logic [1:0]       mask_r;
  logic [BNC_W-1:0] bnc_cnt_r;

  // Bounce shaper: after each edge the changed line alternates new/old, then settles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_r     <= 2'b00;
      mask_r    <= 2'b00;
      bnc_cnt_r <= '0;
    end else if (ab_nxt_s != ab_r) begin
      out_r     <= ab_nxt_s;
      mask_r    <= ab_nxt_s ^ ab_r;
      bnc_cnt_r <= BNC_ONE;
    end else if (bnc_cnt_r == BNC_LAST) begin
      out_r     <= ab_r;
      bnc_cnt_r <= '0;
    end else if (bnc_cnt_r != '0) begin
      out_r     <= out_r ^ mask_r;
      bnc_cnt_r <= bnc_cnt_r + BNC_ONE;
    end else begin
      out_r     <= ab_r;
    end
  end

  assign a = out_r[1];
  assign b = out_r[0];
`else
  assign a = ab_r[1];
  assign b = ab_r[0];
`endif

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Scoreboard bench for quad_encoder_gen: the driver pushes expected edges and
// completions from a phase-arithmetic model; a negedge monitor pops and compares.
module tb_quad_encoder_gen;

  localparam int Q    = 4;
  localparam int PMAX = 3;
  localparam int CYC  = 4 * Q;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_dir = 1'b0;
  logic [15:0] cmd_steps = 16'd0;
  logic        abort = 1'b0;
  logic        cmd_ready, a, b, busy, done;
  logic [15:0] steps_done, position;

  quad_encoder_gen #(.QTR_CYCLES(Q), .POS_MAX(PMAX)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .abort(abort), .a(a), .b(b),
    .busy(busy), .done(done), .steps_done(steps_done), .position(position)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int t; logic [1:0] ab; } ab_ev_t;
  typedef struct { int t; int sd; int pos; } done_ev_t;

  ab_ev_t   ab_q[$];
  done_ev_t done_q[$];
  int  n_vec = 0;
  int  n_err = 0;
  bit  in_reset = 1'b1;
  int  pos_m = 0;
  logic [1:0] prev_ab = 2'b00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phase p of a cycle is 0..3; CW has a high in phases 1,2 and
  // b high in phases 2,3; CCW is the same pattern with the channels swapped.
  task automatic push_expect(input int acc, input logic d, input int steps, input int abort_at);
    int eff;
    ab_ev_t e;
    done_ev_t de;
    eff = steps;
    if (abort_at > 0 && steps > 0) begin
      int k;
      k = (abort_at - 1) / CYC + 1;
      if (k < eff) eff = k;
    end
    for (int j = 1; j <= 4 * eff; j++) begin
      int p;
      logic ea, eb;
      p  = j % 4;
      ea = (p == 1) || (p == 2);
      eb = (p == 2) || (p == 3);
      e.t  = acc + Q * j;
      e.ab = d ? {eb, ea} : {ea, eb};
      ab_q.push_back(e);
    end
    for (int s = 0; s < eff; s++) begin
      if (!d) begin
        if (pos_m < PMAX) pos_m++;
      end else begin
        if (pos_m > 0) pos_m--;
      end
    end
    de.t   = (steps == 0) ? acc : acc + CYC * eff;
    de.sd  = eff;
    de.pos = pos_m;
    done_q.push_back(de);
  endtask

  // Issue one command once the DUT is ready; junk cmd_valid while busy must be ignored.
  task automatic run_cmd(input logic d, input int steps, input int abort_at, input int gap);
    int acc;
    int budget;
    budget = 0;
    while (cmd_ready !== 1'b1) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_dir   = 1'($urandom);
      cmd_steps = 16'($urandom);
      @(posedge clk); #1;
      budget++;
      if (budget > 3000) begin
        chk("ready_timeout", 32'd0, 32'd1);
        cmd_valid = 1'b0;
        return;
      end
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      abort = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    cmd_valid = 1'b1;
    cmd_dir   = d;
    cmd_steps = 16'(steps);
    abort     = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    acc = cyc;
    cmd_valid = 1'b0;
    abort     = 1'b0;
    push_expect(acc, d, steps, abort_at);
    chk("busy_after_accept", busy, (steps != 0));
    chk("ready_after_accept", cmd_ready, (steps == 0));
    if (abort_at > 0 && steps > 0) begin
      while (cyc + 1 < acc + abort_at) begin
        @(posedge clk); #1;
      end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
    end
  endtask

  task automatic mid_run_reset();
    run_cmd(1'b0, 3, 0, 0);
    repeat (2 * Q + 1) @(posedge clk);
    #1;
    chk("pre_reset_ab", {a, b}, 2'b11);
    in_reset = 1'b1;
    ab_q.delete();
    done_q.delete();
    reset_n = 1'b0;
    #1;
    chk("async_reset_a", a, 1'b0);
    chk("async_reset_b", b, 1'b0);
    chk("async_reset_busy", busy, 1'b0);
    chk("async_reset_ready", cmd_ready, 1'b1);
    chk("async_reset_steps_done", steps_done, 16'd0);
    chk("async_reset_position", position, 16'd0);
    pos_m = 0;
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    in_reset = 1'b0;
  endtask

  // Monitor: every a/b change and every done pulse is matched against the queues.
  always @(negedge clk) begin
    if (in_reset) begin
      prev_ab = {a, b};
    end else begin
      if ({a, b} != prev_ab) begin
        if (ab_q.size() == 0) begin
          chk("unexpected_edge", {a, b}, prev_ab);
        end else begin
          ab_ev_t e;
          e = ab_q.pop_front();
          chk("edge_time", cyc, e.t);
          chk("edge_value", {a, b}, e.ab);
        end
      end
      prev_ab = {a, b};
      if (done === 1'b1) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", done, 1'b0);
        end else begin
          done_ev_t de;
          de = done_q.pop_front();
          chk("done_time", cyc, de.t);
          chk("done_steps_done", steps_done, de.sd);
          chk("done_position", position, de.pos);
          chk("done_ready", cmd_ready, 1'b1);
          chk("done_busy", busy, 1'b0);
        end
      end
    end
  end

  initial begin
    int budget;
    #3;
    chk("reset_a", a, 1'b0);
    chk("reset_b", b, 1'b0);
    chk("reset_ready", cmd_ready, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_steps_done", steps_done, 16'd0);
    chk("reset_position", position, 16'd0);
    #10 reset_n = 1'b1;
    @(posedge clk); #1;
    in_reset = 1'b0;

    run_cmd(1'b0, 3, 0, 1);          // CW 3: position 0 -> 3
    run_cmd(1'b1, 5, 0, 0);          // CCW 5: saturates at 0 after 3 cycles
    run_cmd(1'b0, 4, 0, 0);          // CW 4: saturates at POS_MAX
    run_cmd(1'b1, 10, Q + 2, 0);     // abort in quarter 2 of the first cycle
    run_cmd(1'b0, 0, 0, 0);          // zero-length command
    run_cmd(1'b0, 0, 0, 0);          // another, accepted in the done cycle
    run_cmd(1'b1, 65535, 3, 2);      // maximum count, aborted early
    mid_run_reset();
    run_cmd(1'b0, 2, 0, 0);          // accepted after reset release

    for (int n = 0; n < 40; n++) begin
      int st;
      int ab_at;
      st    = $urandom_range(0, 5);
      ab_at = 0;
      if (st > 0 && $urandom_range(0, 3) == 0) ab_at = $urandom_range(1, CYC * st);
      run_cmd(1'($urandom), st, ab_at, $urandom_range(0, 2));
    end

    budget = 0;
    while ((done_q.size() != 0 || ab_q.size() != 0) && budget < 2000) begin
      @(posedge clk);
      budget++;
    end
    @(posedge clk); #1;
    chk("pending_edges", ab_q.size(), 0);
    chk("pending_done", done_q.size(), 0);
    chk("final_ready", cmd_ready, 1'b1);
    chk("final_position", position, pos_m);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
